wb_ram_responder: RTL and testbench
===================================

Name: wb_ram_responder

Overview:
- Wishbone B4 pipelined responder that services 8-bit read/write requests from the SPI-driven Wishbone initiator in main.
- Converts each request into a timed asynchronous-SRAM cycle on the shared PET bus: address, data, OE and WE.
- Drives the RAM pins only while the bus arbiter grants the bus (CPU held off via BE).
- Requests outside the RAM window are acknowledged without touching RAM.

Parameters:
DATA_WIDTH, 8, Wishbone/RAM data width
WB_ADDR_WIDTH, 20, Wishbone address width
RAM_ADDR_WIDTH, 17, RAM address width; RAM window is wb_addr_i[WB_ADDR_WIDTH-1:RAM_ADDR_WIDTH] == 0
READ_WAIT, 2, cycles ram_oe_o held before data sample (1..15)
WRITE_PULSE, 2, cycles ram_we_o held high (1..15)

Ports:
clock_i  in  1  64 MHz system clock
reset_i  in  1  synchronous active-high reset
wb_addr_i  in  WB_ADDR_WIDTH  request address
wb_data_i  in  DATA_WIDTH  write data
wb_data_o  out  DATA_WIDTH  read data, valid while wb_ack_o
wb_we_i  in  1  1 = write
wb_cyc_i  in  1  bus cycle active
wb_stb_i  in  1  request strobe
wb_stall_o  out  1  request not accepted this cycle
wb_ack_o  out  1  one-cycle completion pulse
bus_grant_i  in  1  arbiter grants PET bus to FPGA
busy_o  out  1  RAM cycle in progress; arbiter must not revoke grant
ram_addr_o  out  RAM_ADDR_WIDTH  RAM address
ram_addr_oe  out  1  address output enable
ram_data_i  in  DATA_WIDTH  RAM read data
ram_data_o  out  DATA_WIDTH  RAM write data
ram_data_oe  out  1  data output enable
ram_oe_o  out  1  RAM output enable, active high
ram_we_o  out  1  RAM write enable, active high

Behaviour:
- Reset state: IDLE.
  - wb_ack_o=0, wb_stall_o=1, wb_data_o=0, busy_o=0.
  - ram_addr_oe=0, ram_data_oe=0, ram_oe_o=0, ram_we_o=0, ram_addr_o=0, ram_data_o=0.
- Reset mid-operation: all strobes and enables drop at the next edge. No ack is issued.
- wb_stall_o = !(state==IDLE && bus_grant_i), registered. It is 1 during reset and in every non-IDLE state.
- Acceptance: a request is accepted on an edge where wb_cyc_i && wb_stb_i && !wb_stall_o. Address, we and data are latched at that edge.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
  - IDLE: on acceptance in range, go to READ (we=0) or WR_SETUP (we=1). On acceptance out of range, go to ACK.
  - READ:
    - ram_addr_oe=1, ram_oe_o=1, ram_data_oe=0.
    - Lasts exactly READ_WAIT cycles, counted by a down-counter.
    - wb_data_o is captured from ram_data_i at the edge ending the last READ cycle; then go to ACK.
  - WR_SETUP: 1 cycle. ram_addr_oe=1, ram_data_oe=1, ram_we_o=0.
  - WR_PULSE: WRITE_PULSE cycles with ram_we_o=1. Address and data still driven.
  - WR_HOLD: 1 cycle. ram_we_o=0, address and data still driven.
  - ACK:
    - wb_ack_o=1 for exactly 1 cycle; all RAM enables are 0; then return to IDLE.
    - For an out-of-range read, wb_data_o=8'hFF. For an out-of-range write, nothing is written.
- Latency, counting the first cycle after the acceptance edge as cycle 1:
  - In-range read: ack in cycle READ_WAIT+1.
  - In-range write: ack in cycle WRITE_PULSE+3.
  - Out-of-range access: ack in cycle 1.
- Write data is never driven while ram_oe_o=1. ram_oe_o and ram_we_o are never both high.
- busy_o=1 in READ, WR_SETUP, WR_PULSE and WR_HOLD. It is 0 in IDLE and ACK.
- wb_cyc_i drop mid-operation: the RAM cycle completes with full timing (no truncated WE pulse). The ACK state is still traversed, but wb_ack_o is suppressed if wb_cyc_i=0 in that cycle.
- bus_grant_i low in IDLE: requests stall. Grant loss while busy_o=1 is an arbiter protocol violation; the block ignores it and completes the cycle.
- wb_stall_o is 1 in ACK, so back-to-back requests are accepted no sooner than the first IDLE cycle after ACK.
- Address wrap: ram_addr_o = wb_addr_i[RAM_ADDR_WIDTH-1:0]. Address 17'h1FFFF is valid.

Test Plan:
- Reset while in WR_PULSE (ram_we_o=1) -> next cycle ram_we_o=0, ram_data_oe=0, ram_addr_oe=0, no wb_ack_o, wb_stall_o=1 until reset released and bus_grant_i=1.
- Write 8'hA5 to 20'h01234, grant=1, defaults -> WR_SETUP 1 cycle with ram_addr_o=17'h01234, ram_data_o=8'hA5, ram_we_o=0; ram_we_o=1 for exactly 2 cycles; 1 hold cycle; wb_ack_o pulse in cycle 5; ram_oe_o stays 0 throughout.
- Read 20'h1FFFF with RAM model returning 8'h3C -> ram_oe_o=1 for 2 cycles, wb_ack_o in cycle 3, wb_data_o=8'h3C, ram_data_oe=0 throughout.
- Read 20'h20000 (out of range) -> no ram_oe_o or ram_addr_oe activity, wb_ack_o in cycle 1, wb_data_o=8'hFF. A write to 20'hFFFFF likewise shows no ram_we_o.
- bus_grant_i=0 with stb held high for 10 cycles -> wb_stall_o=1 and no RAM activity. Grant raised -> accepted on the next edge after stall falls.
- Back-to-back write then read at the same address -> read returns written value; no cycle has ram_oe_o&&ram_we_o or ram_oe_o&&ram_data_oe. Repeat with READ_WAIT=1, WRITE_PULSE=4 and check latencies of 2 and 7 cycles.

Source files
------------

// File: rtl/wb_ram_responder_if.sv
// Wishbone B4 pipelined request/response bundle between the SPI-driven
// initiator and the RAM responder. Signal names keep the responder's view
// (_i into the responder, _o out of it) so both ends read the same names.
interface wb_ram_responder_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int WB_ADDR_WIDTH = 20
);
    logic [WB_ADDR_WIDTH-1:0] wb_addr_i;
    logic [DATA_WIDTH-1:0]    wb_data_i;
    logic [DATA_WIDTH-1:0]    wb_data_o;
    logic                     wb_we_i;
    logic                     wb_cyc_i;
    logic                     wb_stb_i;
    logic                     wb_stall_o;
    logic                     wb_ack_o;

    // Responder side: receives requests, returns stall/ack/read data.
    modport slave (
        input  wb_addr_i,
        input  wb_data_i,
        input  wb_we_i,
        input  wb_cyc_i,
        input  wb_stb_i,
        output wb_data_o,
        output wb_stall_o,
        output wb_ack_o
    );

    // Initiator side: issues requests, observes stall/ack/read data.
    modport master (
        output wb_addr_i,
        output wb_data_i,
        output wb_we_i,
        output wb_cyc_i,
        output wb_stb_i,
        input  wb_data_o,
        input  wb_stall_o,
        input  wb_ack_o
    );
endinterface

// File: rtl/wb_ram_responder.sv
// Wishbone B4 pipelined responder that turns 8-bit read/write requests into
// timed asynchronous-SRAM cycles on the shared PET bus. RAM pins are only
// driven while the arbiter has granted the bus; busy_o tells the arbiter the
// grant must not be revoked. Requests outside the RAM window are acknowledged
// without touching the RAM (reads return all ones).
//
// All RAM-side strobes/enables are registered from the next state so the
// SRAM pins never glitch through combinational decode.
module wb_ram_responder #(
    parameter int DATA_WIDTH     = 8,
    parameter int WB_ADDR_WIDTH  = 20,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int READ_WAIT      = 2,
    parameter int WRITE_PULSE    = 2
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    wb_ram_responder_if.slave         wb,
    input  logic                      bus_grant_i,
    output logic                      busy_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic                      ram_addr_oe,
    input  logic [DATA_WIDTH-1:0]     ram_data_i,
    output logic [DATA_WIDTH-1:0]     ram_data_o,
    output logic                      ram_data_oe,
    output logic                      ram_oe_o,
    output logic                      ram_we_o
);

    // READ_WAIT and WRITE_PULSE are limited to 1..15, so a 4-bit
    // down-counter loaded with (length-1) covers every legal timing.
    localparam int            CNT_WIDTH  = 4;
    localparam logic [CNT_WIDTH-1:0] READ_LOAD  = CNT_WIDTH'(READ_WAIT - 1);
    localparam logic [CNT_WIDTH-1:0] PULSE_LOAD = CNT_WIDTH'(WRITE_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_ACK
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      stall_q, stall_d;
    logic                      addr_oe_q, addr_oe_d;
    logic                      data_oe_q, data_oe_d;
    logic                      oe_q, oe_d;
    logic                      we_q, we_d;

    logic                      in_window;
    logic                      accept;

    // The RAM window is every address whose bits above the RAM width are
    // zero; when the two widths match, every address is in the window.
    generate
        if (WB_ADDR_WIDTH > RAM_ADDR_WIDTH) begin : g_window
            assign in_window = ~|wb.wb_addr_i[WB_ADDR_WIDTH-1:RAM_ADDR_WIDTH];
        end else begin : g_no_window
            assign in_window = 1'b1;
        end
    endgenerate

    // A request is taken only in IDLE while the registered stall is low.
    assign accept = (state_q == S_IDLE) && wb.wb_cyc_i && wb.wb_stb_i && !stall_q;

    // Next-state, counter and datapath latching for the RAM cycle sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_window) begin
                        addr_d = wb.wb_addr_i[RAM_ADDR_WIDTH-1:0];
                        if (wb.wb_we_i) begin
                            wdata_d = wb.wb_data_i;
                            state_d = S_WR_SETUP;
                        end else begin
                            cnt_d   = READ_LOAD;
                            state_d = S_READ;
                        end
                    end else begin
                        // Outside the window: answer straight away, reads
                        // see an all-ones byte, writes are dropped.
                        if (!wb.wb_we_i) begin
                            rdata_d = '1;
                        end
                        state_d = S_ACK;
                    end
                end
            end

            S_READ: begin
                if (cnt_q == '0) begin
                    rdata_d = ram_data_i;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_WR_SETUP: begin
                cnt_d   = PULSE_LOAD;
                state_d = S_WR_PULSE;
            end

            S_WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_WR_HOLD: begin
                state_d = S_ACK;
            end

            S_ACK: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin enables for the cycle about to start, decoded from the next state.
    // Read (OE) and write (WE/data drive) states are disjoint, so OE can never
    // coincide with WE or with driven write data.
    always_comb begin
        addr_oe_d = 1'b0;
        data_oe_d = 1'b0;
        oe_d      = 1'b0;
        we_d      = 1'b0;
        stall_d   = !((state_d == S_IDLE) && bus_grant_i);

        case (state_d)
            S_READ: begin
                addr_oe_d = 1'b1;
                oe_d      = 1'b1;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                addr_oe_d = 1'b1;
                data_oe_d = 1'b1;
            end
            S_WR_PULSE: begin
                addr_oe_d = 1'b1;
                data_oe_d = 1'b1;
                we_d      = 1'b1;
            end
            default: begin
                addr_oe_d = 1'b0;
            end
        endcase
    end

    // State, datapath and registered pin drivers; reset drops every enable
    // and returns to IDLE with the bus stalled.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            stall_q   <= 1'b1;
            addr_oe_q <= 1'b0;
            data_oe_q <= 1'b0;
            oe_q      <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            stall_q   <= stall_d;
            addr_oe_q <= addr_oe_d;
            data_oe_q <= data_oe_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
        end
    end

    // The ACK state is always traversed; the pulse itself is withheld when
    // the initiator has already abandoned the bus cycle.
    assign wb.wb_ack_o   = (state_q == S_ACK) && wb.wb_cyc_i;
    assign wb.wb_stall_o = stall_q;
    assign wb.wb_data_o  = rdata_q;

    // The arbiter may not take the bus back while address lines are driven.
    assign busy_o      = addr_oe_q;
    assign ram_addr_o  = addr_q;
    assign ram_addr_oe = addr_oe_q;
    assign ram_data_o  = wdata_q;
    assign ram_data_oe = data_oe_q;
    assign ram_oe_o    = oe_q;
    assign ram_we_o    = we_q;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Self-checking bench for wb_ram_responder. Two instances run in lockstep on
// the same request stream: instance 0 with READ_WAIT=2/WRITE_PULSE=2 and
// instance 1 with READ_WAIT=1/WRITE_PULSE=4. Each has its own SRAM model.
// Expectations come from a byte-array reference memory and latency/pulse
// formulas derived from the timing rules.
module tb_wb_ram_responder;
    localparam int DW        = 8;
    localparam int AW        = 20;
    localparam int RAW       = 17;
    localparam int RAM_WORDS = 1 << RAW;

    localparam int RW_0 = 2;
    localparam int WP_0 = 2;
    localparam int RW_1 = 1;
    localparam int WP_1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst;
    logic          grant;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;

    logic           ack_s     [2];
    logic           stall_s   [2];
    logic [DW-1:0]  rdat_s    [2];
    logic           busy_s    [2];
    logic [RAW-1:0] ram_addr_s[2];
    logic           addr_oe_s [2];
    logic [DW-1:0]  ram_wd_s  [2];
    logic           data_oe_s [2];
    logic           oe_s      [2];
    logic           we_s      [2];

    int vectors     = 0;
    int miscompares = 0;

    // Power-on contents of both the SRAM models and the reference memory.
    function automatic logic [7:0] init_pat(input int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    endfunction

    function automatic int rw_of(input int i);
        return (i == 0) ? RW_0 : RW_1;
    endfunction

    function automatic int wp_of(input int i);
        return (i == 0) ? WP_0 : WP_1;
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int RW = (gi == 0) ? RW_0 : RW_1;
            localparam int WP = (gi == 0) ? WP_0 : WP_1;

            wb_ram_responder_if #(.DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW)) bus ();

            logic           busy;
            logic [RAW-1:0] ram_addr;
            logic           ram_addr_oe;
            logic [DW-1:0]  ram_rd;
            logic [DW-1:0]  ram_wd;
            logic           ram_data_oe;
            logic           ram_oe;
            logic           ram_we;
            logic [DW-1:0]  mem [0:RAM_WORDS-1];

            initial begin
                for (int a = 0; a < RAM_WORDS; a++) mem[a] <= init_pat(a);
            end

            // SRAM model: writes while WE is high, drives data only under OE.
            always @(posedge clk) begin
                if (ram_we) mem[ram_addr] <= ram_wd;
            end
            assign ram_rd = ram_oe ? mem[ram_addr] : '0;

            assign bus.wb_addr_i = addr;
            assign bus.wb_data_i = wdata;
            assign bus.wb_we_i   = we;
            assign bus.wb_cyc_i  = cyc;
            assign bus.wb_stb_i  = stb;

            wb_ram_responder #(
                .DATA_WIDTH    (DW),
                .WB_ADDR_WIDTH (AW),
                .RAM_ADDR_WIDTH(RAW),
                .READ_WAIT     (RW),
                .WRITE_PULSE   (WP)
            ) dut (
                .clock_i    (clk),
                .reset_i    (srst),
                .wb         (bus),
                .bus_grant_i(grant),
                .busy_o     (busy),
                .ram_addr_o (ram_addr),
                .ram_addr_oe(ram_addr_oe),
                .ram_data_i (ram_rd),
                .ram_data_o (ram_wd),
                .ram_data_oe(ram_data_oe),
                .ram_oe_o   (ram_oe),
                .ram_we_o   (ram_we)
            );

            assign ack_s[gi]      = bus.wb_ack_o;
            assign stall_s[gi]    = bus.wb_stall_o;
            assign rdat_s[gi]     = bus.wb_data_o;
            assign busy_s[gi]     = busy;
            assign ram_addr_s[gi] = ram_addr;
            assign addr_oe_s[gi]  = ram_addr_oe;
            assign ram_wd_s[gi]   = ram_wd;
            assign data_oe_s[gi]  = ram_data_oe;
            assign oe_s[gi]       = ram_oe;
            assign we_s[gi]       = ram_we;
        end
    endgenerate

    // Reference memory: only bytes written through the bus are stored.
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] model_rd(input logic [AW-1:0] a);
        int idx;
        if ((a >> RAW) != 0) return 8'hFF;
        idx = int'(a[RAW-1:0]);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return init_pat(idx);
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, i, got, exp);
        end
    endtask

    // Waits (bounded) until both instances show stall low at a falling edge.
    task automatic wait_ready();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!(stall_s[0] === 1'b0 && stall_s[1] === 1'b0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("stall_release", 0, 32'(waited < 50), 32'd1);
    endtask

    // One complete Wishbone transaction on both instances, with per-cycle
    // pin tallies compared against the timing formulas.
    task automatic do_op(input logic w, input logic [AW-1:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd);
        bit             inr;
        logic [RAW-1:0] a17;
        int             lat[2], wec[2], oec[2], busyc[2], bad[2];
        bit             done[2];
        logic [7:0]     got_rd[2];
        int             k;

        inr = ((a >> RAW) == 0);
        a17 = a[RAW-1:0];
        for (int i = 0; i < 2; i++) begin
            lat[i] = 0; wec[i] = 0; oec[i] = 0; busyc[i] = 0; bad[i] = 0;
            done[i] = 1'b0; got_rd[i] = '0;
        end

        wait_ready();
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1 stb = 1'b0;

        k = 0;
        while (!(done[0] && done[1]) && k < 40) begin
            @(negedge clk);
            k++;
            for (int i = 0; i < 2; i++) begin
                if (!done[i]) begin
                    if (oe_s[i] === 1'b1) oec[i]++;
                    if (we_s[i] === 1'b1) wec[i]++;
                    if (busy_s[i] === 1'b1) busyc[i]++;
                    if (oe_s[i] && we_s[i]) bad[i]++;
                    if (oe_s[i] && data_oe_s[i]) bad[i]++;
                    if (addr_oe_s[i] !== busy_s[i]) bad[i]++;
                    if (data_oe_s[i] !== (busy_s[i] && w)) bad[i]++;
                    if (busy_s[i] && ram_addr_s[i] !== a17) bad[i]++;
                    if (data_oe_s[i] && ram_wd_s[i] !== d) bad[i]++;
                    if (stall_s[i] !== 1'b1) bad[i]++;
                    if (inr && w && k == 1 && (we_s[i] || !data_oe_s[i])) bad[i]++;
                    if (inr && w && k == wp_of(i) + 2 && we_s[i]) bad[i]++;
                    if (ack_s[i] === 1'b1) begin
                        done[i]   = 1'b1;
                        lat[i]    = k;
                        got_rd[i] = rdat_s[i];
                    end
                end
            end
        end
        cyc = 1'b0;

        for (int i = 0; i < 2; i++) begin
            int exp_lat;
            exp_lat = !inr ? 1 : (w ? wp_of(i) + 3 : rw_of(i) + 1);
            chk("ack_seen",    i, 32'(done[i]), 32'd1);
            chk("ack_latency", i, 32'(lat[i]), 32'(exp_lat));
            chk("we_cycles",   i, 32'(wec[i]), 32'((inr && w) ? wp_of(i) : 0));
            chk("oe_cycles",   i, 32'(oec[i]), 32'((inr && !w) ? rw_of(i) : 0));
            chk("busy_cycles", i, 32'(busyc[i]),
                32'(!inr ? 0 : (w ? wp_of(i) + 2 : rw_of(i))));
            chk("pin_protocol", i, 32'(bad[i]), 32'd0);
            if (!w) chk("read_data", i, 32'(got_rd[i]), 32'(exp_rd));
        end
        $display("txn %s addr=%05h wdata=%02h | dut0 lat=%0d rd=%02h | dut1 lat=%0d rd=%02h | exp rd=%02h",
                 w ? "WR" : "RD", a, d, lat[0], got_rd[0], lat[1], got_rd[1], exp_rd);

        if (w && inr) ref_mem[int'(a17)] = d;
    endtask

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [7:0]    exp_rd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int ackc[2];
        int wec2[2];

        tbl[0] = '{1'b1, 20'h01234, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 20'h01234, 8'h00, 8'hA5};
        tbl[2] = '{1'b1, 20'h1FFFF, 8'h3C, 8'h00};
        tbl[3] = '{1'b0, 20'h1FFFF, 8'h00, 8'h3C};
        tbl[4] = '{1'b0, 20'h20000, 8'h00, 8'hFF};
        tbl[5] = '{1'b1, 20'hFFFFF, 8'h77, 8'h00};
        tbl[6] = '{1'b0, 20'h1FFFF, 8'h00, 8'h3C};
        tbl[7] = '{1'b0, 20'h00000, 8'h00, 8'h5A};
        tbl[8] = '{1'b1, 20'h00000, 8'h00, 8'h00};
        tbl[9] = '{1'b0, 20'h00000, 8'h00, 8'h00};

        srst = 1'b1; grant = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdata = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ctrl", i,
                32'({ack_s[i], stall_s[i], busy_s[i], addr_oe_s[i], data_oe_s[i], oe_s[i], we_s[i]}),
                32'b0100000);
            chk("reset_data", i, 32'({rdat_s[i], ram_wd_s[i]}), 32'd0);
            chk("reset_addr", i, 32'(ram_addr_s[i]), 32'd0);
        end
        grant = 1'b1;
        srst  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("stall_after_reset", i, 32'(stall_s[i]), 32'd0);

        // Table-driven directed transactions.
        for (int t = 0; t < 10; t++) do_op(tbl[t].w, tbl[t].a, tbl[t].d, tbl[t].exp_rd);

        // No grant: requests must stall with no RAM activity.
        grant = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 20'h00100;
        for (int i = 0; i < 2; i++) ackc[i] = 0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (stall_s[i] !== 1'b1 || busy_s[i] || addr_oe_s[i] || oe_s[i] || ack_s[i]) ackc[i]++;
        end
        for (int i = 0; i < 2; i++) chk("no_grant_stall", i, 32'(ackc[i]), 32'd0);
        grant = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("grant_stall_drop", i, 32'(stall_s[i]), 32'd0);
            chk("grant_not_yet_busy", i, 32'(busy_s[i]), 32'd0);
        end
        do_op(1'b0, 20'h00100, 8'h00, model_rd(20'h00100));

        // Reset while the WE pulse is active.
        wait_ready();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 20'h0AAAA; wdata = 8'hC3;
        @(posedge clk);
        #1 stb = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) chk("we_before_reset", i, 32'(we_s[i]), 32'd1);
        srst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_mid_enables", i,
                32'({we_s[i], data_oe_s[i], addr_oe_s[i], busy_s[i], ack_s[i]}), 32'd0);
            chk("reset_mid_stall", i, 32'(stall_s[i]), 32'd1);
        end
        for (int i = 0; i < 2; i++) ackc[i] = 0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) if (ack_s[i] || stall_s[i] !== 1'b1) ackc[i]++;
        end
        for (int i = 0; i < 2; i++) chk("reset_hold_quiet", i, 32'(ackc[i]), 32'd0);
        srst = 1'b0;
        cyc  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("stall_after_mid_reset", i, 32'(stall_s[i]), 32'd0);

        // Initiator drops cyc mid-write: full WE pulse, no ack.
        wait_ready();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 20'h00300; wdata = 8'h99;
        @(posedge clk);
        #1 stb = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin ackc[i] = 0; wec2[i] = 0; end
        for (int i = 0; i < 2; i++) if (we_s[i]) wec2[i]++;
        cyc = 1'b0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (ack_s[i]) ackc[i]++;
                if (we_s[i]) wec2[i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("cyc_drop_no_ack", i, 32'(ackc[i]), 32'd0);
            chk("cyc_drop_we_pulse", i, 32'(wec2[i]), 32'(wp_of(i)));
        end
        ref_mem[32'h300] = 8'h99;
        do_op(1'b0, 20'h00300, 8'h00, model_rd(20'h00300));

        // Randomised traffic against the reference memory.
        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] ra;
            logic          rw;
            logic [7:0]    rd;
            int            sel;
            sel = $urandom_range(0, 9);
            if (sel <= 5 || sel == 9) ra = AW'(20'h00400 + $urandom_range(0, 15));
            else if (sel <= 7)        ra = AW'(20'h1FFF0 + $urandom_range(0, 15));
            else                      ra = AW'($urandom_range(32'h20000, 32'hFFFFF));
            rw = 1'($urandom_range(0, 1));
            rd = 8'($urandom_range(0, 255));
            do_op(rw, ra, rd, model_rd(ra));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
